muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit that owns the HI/LO registers.
- Responds to the decoder's MDU command set: StartMDU, MoveToMDU, MoveFromMDU and the 3-bit MDUSel.
- Multi-cycle operations are tracked by an internal counter and reported through busy; the hazard unit stalls on start|busy.
- Mid-pipeline exceptions/interrupts suppress commands through cancel.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  StartMDU: begin operation given by sel (0..3)
move_to  input  1  MoveToMDU: write a into HI (sel=4) or LO (sel=5)
sel  input  3  MDUSel: 0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 SELECT_HI, 5 SELECT_LO, 7 none
a  input  32  rs operand
b  input  32  rt operand
cancel  input  1  exception/interrupt in a later stage; suppresses start/move_to this cycle
busy  output  1  operation in progress
out  output  32  read data for mfhi/mflo

Behaviour:
- Reset (asynchronous, active-high): HI=0, LO=0, busy=0, counter=0, operand/result latches=0, out=0. Reset asserted mid-operation aborts the operation; HI/LO stay 0.
- Accepted command: start or move_to, with cancel=0 and busy=0. Commands arriving while busy=1 are ignored; the pipeline must stall, and no queueing is done.
- start && sel==4..7 and move_to && sel==0..3,6,7: ignored, no state change.
- start && move_to both set: start has priority.
- start accepted at edge k:
  - Latch op, a, b; compute the result internally (behavioural * and / are permitted).
  - busy=1 from after edge k.
  - Counter loads N-1, where N = MUL_CYCLES or DIV_CYCLES.
  - At edge k+N: HI/LO are written and busy falls. busy is high for exactly N cycles.
- Result rules:
  - MUL: {HI,LO} = signed 64-bit a*b.
  - MULU: {HI,LO} = unsigned 64-bit a*b.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV with a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - b==0 for DIV/DIVU: operation still occupies N cycles; HI/LO unchanged at completion.
- move_to accepted: HI (sel=4) or LO (sel=5) takes a at the same edge; busy unaffected.
- out (combinational): sel=4 gives HI, sel=5 gives LO, else 0.
  - out reflects committed HI/LO only. During busy, the old value is shown, but the pipeline never reads while busy.
  - A move_to write is visible on out the cycle after the edge.
- cancel is only sampled in the command-accept cycle. Asserting cancel during busy does not abort an in-flight operation, because an accepted operation belongs to an already-committed instruction.
- Counter never wraps; it saturates at 0 when idle.

Test Plan:
- Reset pulse asserted asynchronously mid-cycle -> busy=0 and HI=LO=0 immediately, before the next clk edge; sel=4 gives out=0.
- start, sel=0, a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with sel=1 -> HI=0x00000002, LO=0xFFFFFFFA.
- start, sel=2, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow and zero divisor:
  - sel=2, a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Then sel=3, b=0 -> busy 10 cycles, HI/LO unchanged.
- move_to, sel=4, a=0x12345678, then sel=5, a=0x9ABCDEF0 -> out shows 0x12345678 with sel=4 and 0x9ABCDEF0 with sel=5. The same pair issued while busy=1 or with cancel=1 -> no change.
- start with cancel=1 -> busy stays 0, HI/LO unchanged.
- start sel=0 accepted, then a second start sel=2 on the next cycle while busy -> second ignored; only the mult result is written at cycle 5.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the HI/LO registers.
// Multi-cycle operations run for a fixed number of cycles and commit HI/LO when they finish.
module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_to,
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               div_zero;
    logic               div_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A divide by one in place of zero or the overflow case keeps the divider defined;
    // 0x80000000 / 1 already yields the required overflow quotient and zero remainder.
    always_comb begin
        div_zero = (b_q == 32'd0);
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        b_safe   = (div_zero || div_ovf) ? 32'd1 : b_q;
        prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        quot_s   = $signed(a_q) / $signed(b_safe);
        rem_s    = $signed(a_q) % $signed(b_safe);
        quot_u   = a_q / b_safe;
        rem_u    = a_q % b_safe;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (!sel[2]) begin
                        state_d = ST_BUSY;
                        op_d    = sel[1:0];
                        a_d     = a;
                        b_d     = b;
                        count_d = sel[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                    end
                end else if (move_to && !cancel && !start) begin
                    if (sel == 3'd4) begin
                        hi_d = a;
                    end else if (sel == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        2'd0: {hi_d, lo_d} = prod_s;
                        2'd1: {hi_d, lo_d} = prod_u;
                        2'd2: begin
                            if (!div_zero) begin
                                lo_d = quot_s;
                                hi_d = rem_s;
                            end
                        end
                        default: begin
                            if (!div_zero) begin
                                lo_d = quot_u;
                                hi_d = rem_u;
                            end
                        end
                    endcase
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_BUSY);
        out  = 32'd0;
        if (sel == 3'd4) begin
            out = hi_q;
        end else if (sel == 3'd5) begin
            out = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        move_to;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] out;

    int checks;
    int failures;

    muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .move_to (move_to),
        .sel     (sel),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reads HI then LO through the combinational read port, leaving sel idle.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        sel = 3'd4;
        #1 hi = out;
        sel = 3'd5;
        #1 lo = out;
        sel = 3'd7;
    endtask

    // Issues one start and counts the falling edges that see busy high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; sel = op; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; sel = 3'd7;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_move(input logic [2:0] s, input logic [31:0] av, input logic c);
        @(negedge clk);
        move_to = 1'b1; sel = s; a = av; cancel = c;
        @(negedge clk);
        move_to = 1'b0; sel = 3'd7; cancel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b required=0", busy);
        end
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_hilo got=%h_%h required=0_0", hi, lo);
        end
        reset = 1'b0;
        do_move(3'd4, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        start = 1'b1; sel = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; sel = 3'd4;
        #1;
        checks++;
        if (busy !== 1'b1 || out !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL pre_reset_state got=busy %b hi %h required=busy 1 hi deadbeef", busy, out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset_busy got=%b required=0", busy);
        end
        checks++;
        if (out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_hi got=%h required=0", out);
        end
        sel = 3'd5;
        #1;
        checks++;
        if (out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_lo got=%h required=0", out);
        end
        sel = 3'd7;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        read_hilo(hi, lo);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort got=busy %b %h_%h required=busy 0 0_0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        int cycles;
        logic [31:0] hi, lo;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, cycles);
        read_hilo(hi, lo);
        checks++;
        if (cycles !== 5) begin
            failures++;
            $display("[TB] FAIL mult_busy_cycles got=%0d required=5", cycles);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            failures++;
            $display("[TB] FAIL mult_result got=%h_%h required=ffffffff_fffffffa", hi, lo);
        end
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, cycles);
        read_hilo(hi, lo);
        checks++;
        if (cycles !== 5) begin
            failures++;
            $display("[TB] FAIL multu_busy_cycles got=%0d required=5", cycles);
        end
        checks++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            failures++;
            $display("[TB] FAIL multu_result got=%h_%h required=00000002_fffffffa", hi, lo);
        end
    endtask

    task automatic test_div();
        int cycles;
        logic [31:0] hi, lo;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, cycles);
        read_hilo(hi, lo);
        checks++;
        if (cycles !== 10) begin
            failures++;
            $display("[TB] FAIL div_busy_cycles got=%0d required=10", cycles);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("[TB] FAIL div_result got=%h_%h required=ffffffff_fffffffd", hi, lo);
        end
        run_op(3'd3, 32'd100, 32'd7, cycles);
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            failures++;
            $display("[TB] FAIL divu_result got=%h_%h required=00000002_0000000e", hi, lo);
        end
    endtask

    task automatic test_div_edge();
        int cycles;
        logic [31:0] hi, lo;
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cycles);
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            failures++;
            $display("[TB] FAIL div_overflow got=%h_%h required=00000000_80000000", hi, lo);
        end
        run_op(3'd3, 32'h55555555, 32'd0, cycles);
        read_hilo(hi, lo);
        checks++;
        if (cycles !== 10) begin
            failures++;
            $display("[TB] FAIL divzero_busy_cycles got=%0d required=10", cycles);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            failures++;
            $display("[TB] FAIL divzero_unchanged got=%h_%h required=00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_move_to();
        int cycles;
        logic [31:0] hi, lo;
        do_move(3'd4, 32'h12345678, 1'b0);
        do_move(3'd5, 32'h9ABCDEF0, 1'b0);
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("[TB] FAIL move_to got=%h_%h required=12345678_9abcdef0", hi, lo);
        end
        sel = 3'd7;
        #1;
        checks++;
        if (out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL out_sel_none got=%h required=0", out);
        end
        do_move(3'd4, 32'h11111111, 1'b1);
        do_move(3'd5, 32'h22222222, 1'b1);
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("[TB] FAIL move_to_cancel got=%h_%h required=12345678_9abcdef0", hi, lo);
        end
        // A zero-divisor divide keeps HI/LO intact, exposing any move_to that slips through busy.
        @(negedge clk);
        start = 1'b1; sel = 3'd3; a = 32'd9; b = 32'd0;
        @(negedge clk);
        start = 1'b0; move_to = 1'b1; sel = 3'd4; a = 32'h33333333;
        @(negedge clk);
        sel = 3'd5; a = 32'h44444444;
        @(negedge clk);
        move_to = 1'b0; sel = 3'd4;
        #1;
        checks++;
        if (busy !== 1'b1 || out !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL move_to_busy_hi got=busy %b %h required=busy 1 12345678", busy, out);
        end
        sel = 3'd7;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("[TB] FAIL move_to_busy got=%h_%h required=12345678_9abcdef0", hi, lo);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] hi, lo;
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; sel = 3'd0; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; sel = 3'd7;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cancel_busy got=%b required=0", busy);
        end
        repeat (6) @(negedge clk);
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("[TB] FAIL cancel_hilo got=%h_%h required=12345678_9abcdef0", hi, lo);
        end
        @(negedge clk);
        start = 1'b1; sel = 3'd6; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0; sel = 3'd7;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_bad_sel got=%b required=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic [31:0] hi, lo;
        @(negedge clk);
        start = 1'b1; sel = 3'd0; a = 32'h00010000; b = 32'h00010000;
        @(negedge clk);
        sel = 3'd2; a = 32'd100; b = 32'd7;
        cycles = 0;
        if (busy) cycles++;
        @(negedge clk);
        start = 1'b0; sel = 3'd7;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles !== 5) begin
            failures++;
            $display("[TB] FAIL b2b_busy_cycles got=%0d required=5", cycles);
        end
        @(negedge clk);
        read_hilo(hi, lo);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL b2b_result got=busy %b %h_%h required=busy 0 00000001_00000000",
                     busy, hi, lo);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        move_to  = 1'b0;
        sel      = 3'd7;
        a        = 32'd0;
        b        = 32'd0;
        cancel   = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_move_to();
        test_cancel();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
